// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage CPU. Detects load-use
// hazards and taken branch/jump redirects, and holds the front of the pipe
// while a multi-cycle mul/div occupies the EX stage.
//
// Optional feature macro: HAZ_PERF_CNT_EN (adds perf_stall_cyc/perf_flush_cnt).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   Rs_ID, Rt_ID            source register fields of the ID instruction
//   UseRs_ID, UseRt_ID      ID instruction actually reads rs / rt
//   MemToReg_Ex, RegWr_Ex   EX instruction is a load / writes a register
//   WrReg_Ex                EX destination register
//   Redirect_Ex             taken branch/jump resolved in EX
//   MulDiv_Ex               EX instruction is mul/div
//   stall_pc, stall_if_id, stall_id_ex   hold controls
//   flush_if_id, flush_id_ex, bubble_ex_mem   bubble-insert controls
//   md_busy                 mul/div occupying EX
//   perf_stall_cyc, perf_flush_cnt (HAZ_PERF_CNT_EN only)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal flow; redirect > load-use > mul/div entry
// S_MD_BUSY | mul/div occupying EX, cnt counts remaining stall cycles

module pipe_hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic       UseRs_ID,
  input  logic       UseRt_ID,
  input  logic       MemToReg_Ex,
  input  logic       RegWr_Ex,
  input  logic [4:0] WrReg_Ex,
  input  logic       Redirect_Ex,
  input  logic       MulDiv_Ex,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       bubble_ex_mem,
  output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [0:0] {S_RUN, S_MD_BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  assign load_use = MemToReg_Ex & RegWr_Ex & (WrReg_Ex != 5'd0) &
                    ((UseRs_ID & (Rs_ID == WrReg_Ex)) |
                     (UseRt_ID & (Rt_ID == WrReg_Ex)));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    bubble_ex_mem = 1'b0;
    md_busy       = 1'b0;
    // Outputs are forced low during reset, not merely reset-derived, since
    // in S_RUN they still follow the live inputs.
    if (rst_n) begin
      case (state)
        S_RUN: begin
          if (Redirect_Ex) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (MulDiv_Ex) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
            md_busy       = 1'b1;
            state_nxt     = S_MD_BUSY;
            // Entry cycle plus the cnt==0 release cycle account for 2 of MD_LAT.
            cnt_nxt       = CNT_W'(MD_LAT - 2);
          end
        end
        S_MD_BUSY: begin
          md_busy = 1'b1;
          if (cnt != '0) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
            cnt_nxt       = cnt - 1'b1;
          end else begin
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc)    perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush_if_id) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with MD_LAT = 4.
// Output vector order: {stall_pc, stall_if_id, stall_id_ex,
//                       flush_if_id, flush_id_ex, bubble_ex_mem, md_busy}

module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs_ID, Rt_ID, WrReg_Ex;
  logic       UseRs_ID, UseRt_ID, MemToReg_Ex, RegWr_Ex, Redirect_Ex, MulDiv_Ex;
  logic       stall_pc, stall_if_id, stall_id_ex;
  logic       flush_if_id, flush_id_ex, bubble_ex_mem, md_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  wire [6:0] obs = {stall_pc, stall_if_id, stall_id_ex,
                    flush_if_id, flush_id_ex, bubble_ex_mem, md_busy};

  localparam logic [6:0] V_IDLE = 7'b000_0000;
  localparam logic [6:0] V_LU   = 7'b110_0100;
  localparam logic [6:0] V_RDR  = 7'b000_1100;
  localparam logic [6:0] V_MDST = 7'b111_0011;
  localparam logic [6:0] V_MDRL = 7'b000_0001;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .MemToReg_Ex(MemToReg_Ex), .RegWr_Ex(RegWr_Ex), .WrReg_Ex(WrReg_Ex),
    .Redirect_Ex(Redirect_Ex), .MulDiv_Ex(MulDiv_Ex),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .bubble_ex_mem(bubble_ex_mem), .md_busy(md_busy)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 2-3 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    Rs_ID = 5'd0; Rt_ID = 5'd0; WrReg_Ex = 5'd0;
    UseRs_ID = 1'b0; UseRt_ID = 1'b0; MemToReg_Ex = 1'b0; RegWr_Ex = 1'b0;
    Redirect_Ex = 1'b0; MulDiv_Ex = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] wr, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
    MemToReg_Ex = 1'b1; RegWr_Ex = 1'b1; WrReg_Ex = wr;
    Rs_ID = rs; UseRs_ID = urs; Rt_ID = rt; UseRt_ID = urt;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);  // hazard on inputs must still be masked
    MulDiv_Ex = 1'b1;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, V_IDLE);
    end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs, V_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    checks++;
    if (obs !== V_LU) begin
      failures++;
      $display("FAIL load_use_rs got=%b exp=%b", obs, V_LU);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL load_use_release got=%b exp=%b", obs, V_IDLE);
    end
    tick();
    set_load(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    #1;
    checks++;
    if (obs !== V_LU) begin
      failures++;
      $display("FAIL load_use_rt got=%b exp=%b", obs, V_LU);
    end
    tick();
    set_load(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);  // matching fields but not read
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL load_use_unused_src got=%b exp=%b", obs, V_IDLE);
    end
    tick();
    set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    MemToReg_Ex = 1'b0;  // ALU op, not a load
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL alu_no_stall got=%b exp=%b", obs, V_IDLE);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_load_r0();
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL load_r0 got=%b exp=%b", obs, V_IDLE);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_redirect();
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    Redirect_Ex = 1'b1;
    #1;
    checks++;
    if (obs !== V_RDR) begin
      failures++;
      $display("FAIL redirect_over_load_use got=%b exp=%b", obs, V_RDR);
    end
    tick();
    clear_inputs();
    Redirect_Ex = 1'b1;
    MulDiv_Ex = 1'b1;
    #1;
    checks++;
    if (obs !== V_RDR) begin
      failures++;
      $display("FAIL redirect_over_muldiv got=%b exp=%b", obs, V_RDR);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL redirect_no_md_entry got=%b exp=%b", obs, V_IDLE);
    end
    tick();
  endtask

  task automatic test_muldiv();
    logic [6:0] exp_seq [0:4];
    exp_seq[0] = V_MDST; exp_seq[1] = V_MDST; exp_seq[2] = V_MDST;
    exp_seq[3] = V_MDRL; exp_seq[4] = V_IDLE;
    for (int i = 0; i < 5; i++) begin
      MulDiv_Ex = (i == 0);
      if (i == 1) begin
        // Hazard inputs during occupancy must be ignored.
        set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        Redirect_Ex = 1'b1;
      end
      if (i == 4) clear_inputs();
      #1;
      checks++;
      if (obs !== exp_seq[i]) begin
        failures++;
        $display("FAIL muldiv_cycle%0d got=%b exp=%b", i, obs, exp_seq[i]);
      end
      tick();
      if (i == 1) clear_inputs();
    end
  endtask

  task automatic test_reset_mid();
    MulDiv_Ex = 1'b1;
    tick();               // entry cycle done, now MD_BUSY cycle 1
    MulDiv_Ex = 1'b0;
    tick();               // MD_BUSY cycle 2
    #1;
    checks++;
    if (obs !== V_MDST) begin
      failures++;
      $display("FAIL mid_busy_before_reset got=%b exp=%b", obs, V_MDST);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL async_reset_mid got=%b exp=%b", obs, V_IDLE);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL after_reset_run got=%b exp=%b", obs, V_IDLE);
    end
    tick();
    test_muldiv();        // full occupancy after the abandoned op
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_v;
    int stall_cnt = 0;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf0;
    perf0 = perf_stall_cyc;
`endif
    for (int i = 0; i < 2 * MD_LAT + 1; i++) begin
      MulDiv_Ex = (i < 2 * MD_LAT);
      if (i == 2 * MD_LAT) exp_v = V_IDLE;
      else if ((i % MD_LAT) == MD_LAT - 1) exp_v = V_MDRL;
      else exp_v = V_MDST;
      #1;
      if (stall_pc === 1'b1) stall_cnt++;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%b exp=%b", i, obs, exp_v);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (stall_cnt != 2 * MD_LAT - 2) begin
      failures++;
      $display("FAIL b2b_stall_cycles got=%0d exp=%0d", stall_cnt, 2 * MD_LAT - 2);
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if (perf_stall_cyc - perf0 !== 32'(2 * MD_LAT - 2)) begin
      failures++;
      $display("FAIL perf_stall_cyc got=%0d exp=%0d", perf_stall_cyc - perf0, 2 * MD_LAT - 2);
    end
`endif
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    test_reset();
    test_load_use();
    test_load_r0();
    test_redirect();
    test_muldiv();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU.
- Detects load-use hazards and taken branch/jump redirects, and sequences multi-cycle mul/div occupancy of the EX stage.
- Drives stall and flush (bubble) controls for the PC, the IF/ID register, the ID/EX register and the EX/MEM register.
- Sits beside the decoder; consumes ID-stage register fields and EX-stage control signals.

Parameters:
- MD_LAT, 32, EX occupancy in cycles of a mul/div instruction (legal range 2..255).
- CNT_W, 8, width of the internal mul/div down-counter; must satisfy 2^CNT_W > MD_LAT.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs_ID  in  5  source register rs of the instruction in ID.
- Rt_ID  in  5  source register rt of the instruction in ID.
- UseRs_ID  in  1  instruction in ID reads rs.
- UseRt_ID  in  1  instruction in ID reads rt.
- MemToReg_Ex  in  1  instruction in EX is a load.
- RegWr_Ex  in  1  instruction in EX writes a register.
- WrReg_Ex  in  5  destination register of the instruction in EX.
- Redirect_Ex  in  1  taken branch or jump resolved in EX this cycle.
- MulDiv_Ex  in  1  instruction in EX is mul/div.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID register.
- stall_id_ex  out  1  hold ID/EX register; this is the stall input of the ID/EX register.
- flush_if_id  out  1  load bubble (all zero) into IF/ID.
- flush_id_ex  out  1  load bubble into ID/EX.
- bubble_ex_mem  out  1  load bubble into EX/MEM.
- md_busy  out  1  mul/div occupying EX.

Behaviour:
- State machine: RUN and MD_BUSY. Internal down-counter cnt, CNT_W bits. Outputs are combinational from the state and the inputs.
- Reset:
  - rst_n low, at any time including mid mul/div, forces state RUN and cnt = 0.
  - All outputs read 0 while rst_n is low.
  - An operation in flight is abandoned; there is no resume.
- RUN, Redirect_Ex = 1 (highest priority):
  - flush_if_id = 1 and flush_id_ex = 1 for exactly that cycle.
  - All stalls = 0.
  - Any load-use condition in the same cycle is ignored.
  - MulDiv_Ex in the same cycle is ignored; MD_BUSY is not entered.
- RUN, load-use:
  - Condition: MemToReg_Ex & RegWr_Ex & (WrReg_Ex != 0) & ((UseRs_ID & Rs_ID == WrReg_Ex) | (UseRt_ID & Rt_ID == WrReg_Ex)).
  - Response: stall_pc = 1, stall_if_id = 1, flush_id_ex = 1.
  - Exactly one bubble results, because the load has left EX on the next cycle.
  - A destination of register 0 never stalls.
- RUN, MulDiv_Ex = 1 with no redirect:
  - Enter MD_BUSY next edge and load cnt = MD_LAT - 2.
  - In the entry cycle itself: stall_pc = stall_if_id = stall_id_ex = 1, bubble_ex_mem = 1, md_busy = 1.
- MD_BUSY:
  - stall_pc = stall_if_id = stall_id_ex = 1, md_busy = 1.
  - bubble_ex_mem = 1 while cnt != 0.
  - While cnt != 0, decrement cnt each cycle.
  - In the cycle with cnt == 0: bubble_ex_mem = 0 and all stalls = 0, so the result passes to EX/MEM and the pipe advances. State returns to RUN next edge.
  - Total EX occupancy is exactly MD_LAT cycles; md_busy is high for exactly MD_LAT cycles.
  - Load-use and Redirect_Ex inputs are ignored in MD_BUSY. The EX instruction is the mul/div, so neither is legal.
- Back-to-back mul/div:
  - After return to RUN, a new MulDiv_Ex in EX re-enters MD_BUSY.
  - No idle cycle is required between operations.
- Flush and stall are never asserted together on the same register; flush wins by construction of the rules above.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs perf_stall_cyc (32 bits) and perf_flush_cnt (32 bits).
  - perf_stall_cyc increments every cycle stall_pc = 1.
  - perf_flush_cnt increments every cycle flush_if_id = 1.
  - Both counters wrap at 2^32 and are cleared by rst_n.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use: lw $5 in EX (MemToReg_Ex = 1, RegWr_Ex = 1, WrReg_Ex = 5) with Rs_ID = 5, UseRs_ID = 1 -> stall_pc = stall_if_id = flush_id_ex = 1 for 1 cycle, then 0.
- Load to register 0: WrReg_Ex = 0, Rs_ID = 0 -> no stall.
- Redirect plus load-use in the same cycle: Redirect_Ex = 1 with the load-use condition true -> flush_if_id = flush_id_ex = 1, stall_pc = 0.
- Mul/div occupancy: MD_LAT = 4, MulDiv_Ex pulse -> md_busy high exactly 4 cycles, bubble_ex_mem high for the first 3, stalls released in the 4th.
- Reset mid-operation: rst_n low on cycle 2 of MD_BUSY -> all outputs 0 immediately (asynchronous). After release: state RUN, and a new MulDiv_Ex gives a full MD_LAT occupancy.
- Back-to-back: two mul/div instructions consecutive -> md_busy high 2×MD_LAT cycles with no idle cycle between. With HAZ_PERF_CNT_EN defined, perf_stall_cyc = 2×MD_LAT − 2.
